nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequencing controller that performs a 4·NIBBLES-bit addition by time-multiplexing a single 4-bit ripple-carry adder slice, one nibble per clock, least significant nibble first. It latches operands on a start request and carries between nibbles in a register. It reports completion with a one-cycle done pulse and holds the result until the next operation. It sits between a requesting datapath stage and the shared 4-bit adder resource, so wide sums cost one adder slice instead of NIBBLES slices.

## Interface
- NIBBLES, default 4, number of 4-bit slices per operand (≥1); operand width W = 4·NIBBLES.
- clk  input  1  sole clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state and outputs.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  W  operand A, sampled with start.
- b  input  W  operand B, sampled with start.
- cin  input  1  carry-in to nibble 0, sampled with start.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse: result valid.
- sum  output  W  result, updated only on the done edge.
- cout  output  1  carry out of bit W-1.
- overflow  output  1  signed overflow = carry into bit W-1 XOR carry out of bit W-1.

## Operation
- States: IDLE, RUN, DONE; reset → IDLE.
- IDLE: start=1 → latch a, b, cin; idx←0; carry←cin; → RUN. start=0 → stay.
- RUN: each edge adds nibble idx of A and B with carry through the 4-bit slice. It stores the 4-bit result into the internal accumulator and sets carry←slice cout[3] and idx←idx+1.
- RUN, last nibble (idx=NIBBLES-1): the same edge loads sum, cout=cout[3], overflow=cout[3]^cout[2] of that slice, then → DONE.
- DONE: done=1 for exactly one cycle. start=1 → latch new operands, → RUN (back-to-back). Otherwise → IDLE.
- start during RUN is ignored; the operation in progress is not disturbed and the request is not queued.
- Operand inputs are don't-care except on the accepting edge.
- sum/cout/overflow hold their values through IDLE and the next RUN until the next done edge.
- idx counter width: clog2(NIBBLES), minimum 1 bit. The counter never wraps past NIBBLES-1.
- NIBBLES=1: single RUN cycle; behaviour otherwise identical.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, overflow=0, state IDLE, carry=0.
- The accepting edge is E0. busy is high in the cycles after E0 … E(NIBBLES-1), i.e. NIBBLES cycles.
- done is high in the single cycle after E(NIBBLES), which is NIBBLES cycles after start is seen.
- Back-to-back throughput: one result per NIBBLES+1 cycles. busy=0 during the DONE cycle.
- reset asserted in any state, including mid-RUN, takes effect on that edge. The partial result is discarded, there is no done pulse, and all outputs return to reset values.
- reset and start asserted on the same edge: reset wins.

## Configuration
- ADDER_SUB_EN defined: adds port sub (input, 1, sampled with start).
  - sub=1: B is bitwise inverted and the initial carry is forced to 1 (cin ignored), giving sum = A − B. cout=1 means no borrow.
  - sub=0: plain addition.
- ADDER_SUB_EN undefined: no sub port; addition only.

## Test plan
All scenarios use NIBBLES=4.
- Reset held 2 cycles, then idle 3 cycles with start=0 → busy=0, done=0, sum=0x0000, cout=0, overflow=0 throughout.
- a=0x1234, b=0x1111, cin=0, start 1 cycle → busy high 4 cycles; done pulses 4 cycles after start with sum=0x2345, cout=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1.
- a=0x00FF, b=0x0001, start; start re-pulsed with a=0xAAAA during RUN, then start held at DONE with a=0x0001, b=0x0001 → first result 0x0100 (mid-RUN start ignored). The second operation starts at DONE with no IDLE cycle and yields 0x0002.
- Start a=0x1234, b=0x4321; assert reset on the 2nd RUN cycle → busy=0 the next cycle, no done pulse, sum=0x0000.
- ADDER_SUB_EN build: a=0x0005, b=0x0007, sub=1, cin=1 → sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005, sub=1 → sum=0x0002, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//
// Performs a 4*NIBBLES-bit addition by reusing a single 4-bit ripple-carry
// slice, one nibble per clock, least significant nibble first. The operands
// are latched when a start request is accepted. The inter-nibble carry is
// held in a register. Completion is flagged by a one-cycle done pulse, and
// the result holds until the next completion.
//
// Optional feature macro: ADDER_SUB_EN. When it is defined, a `sub` input
// turns the operation into A - B. B is inverted and the initial carry is
// forced to 1.
//
// Ports:
//   clk       in   1  rising-edge clock
//   reset     in   1  synchronous, active-high; returns everything to idle/zero
//   start     in   1  operation request, honoured only in IDLE or DONE
//   a, b      in   W  operands (W = 4*NIBBLES), sampled with an accepted start
//   cin       in   1  carry into nibble 0, sampled with an accepted start
//   sub       in   1  (ADDER_SUB_EN only) subtract instead of add
//   busy      out  1  high while nibbles are being processed
//   done      out  1  one-cycle pulse, result valid
//   sum       out  W  result, updated only on the completing edge
//   cout      out  1  carry out of bit W-1
//   overflow  out  1  signed overflow (carry into MSB xor carry out of MSB)

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
`ifdef ADDER_SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   overflow
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;   // operands are latched on this edge
    logic               w_last;     // final nibble is processed on this edge

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_acc;

    logic [W-1:0]       w_b_in;
    logic               w_cin_in;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_sum_nib;
    logic [4:0]         w_carry;    // w_carry[i] is the carry into bit i of the slice
    logic [W-1:0]       w_acc_next;

    // Subtraction is A + ~B + 1, so only the operand and the initial carry change.
`ifdef ADDER_SUB_EN
    assign w_b_in   = sub ? ~b : b;
    assign w_cin_in = sub ? 1'b1 : cin;
`else
    assign w_b_in   = b;
    assign w_cin_in = cin;
`endif

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM next-state decode ----------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // start is ignored here; the running operation is not disturbed
                if (r_idx == LAST_IDX) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // A start seen in DONE goes straight back to RUN with no idle gap.
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    // ---------------- shared 4-bit ripple-carry slice ----------------
    always_comb begin
        w_a_nib    = r_a[r_idx*4 +: 4];
        w_b_nib    = r_b[r_idx*4 +: 4];
        w_carry    = 5'b0;
        w_carry[0] = r_carry;
        w_sum_nib  = 4'b0;
        for (int i = 0; i < 4; i++) begin
            w_sum_nib[i]  = w_a_nib[i] ^ w_b_nib[i] ^ w_carry[i];
            w_carry[i+1] = (w_a_nib[i] & w_b_nib[i]) |
                           (w_a_nib[i] & w_carry[i]) |
                           (w_b_nib[i] & w_carry[i]);
        end
        // The accumulator with the current nibble slotted in. On the last
        // nibble this is the complete result, so sum can load it directly.
        w_acc_next = r_acc;
        w_acc_next[r_idx*4 +: 4] = w_sum_nib;
    end

    // ---------------- operand, carry and result registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_acc    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= a;
                r_b     <= w_b_in;
                r_carry <= w_cin_in;
                r_idx   <= '0;
            end else if (r_state == S_RUN) begin
                r_acc   <= w_acc_next;
                r_carry <= w_carry[4];
                // Hold at the last index rather than wrap; the FSM leaves RUN here.
                if (!w_last) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            if (w_last) begin
                sum      <= w_acc_next;
                cout     <= w_carry[4];
                overflow <= w_carry[4] ^ w_carry[3];
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl (NIBBLES = 4). Drives directed
// scenarios and then randomized operations. Each result is compared with a
// whole-word arithmetic reference model.

module tb_nibble_serial_adder_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;

    nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_sum"},  64'(sum),  64'(prev_sum));
        chk({tag, "_cout"}, 64'(cout), 64'(prev_cout));
        chk({tag, "_ovf"},  64'(overflow), 64'(prev_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_quiet("idle");
        end
    endtask

    // One complete operation. It must be called while the DUT is in IDLE or
    // DONE. It returns in the done cycle, so another op call runs back-to-back.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                      input logic tcin, input logic tsub, input bit midstart);
        logic [W-1:0] bb;
        logic         c0;
        logic [W:0]   full;
        logic         eovf;
        bb = tsub ? ~tbv : tbv;
        c0 = tsub ? 1'b1 : tcin;
        full = {1'b0, ta} + {1'b0, bb} + (W+1)'(c0);
        eovf = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);

        a = ta; b = tbv; cin = tcin; start = 1'b1;
`ifdef ADDER_SUB_EN
        sub = tsub;
`endif
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef ADDER_SUB_EN
        sub = 1'($urandom);
`endif
        for (int i = 0; i < NIB; i++) begin
            chk("run_busy", 64'(busy), 64'd1);
            chk("run_done", 64'(done), 64'd0);
            chk("run_sum_hold", 64'(sum), 64'(prev_sum));
            chk("run_cout_hold", 64'(cout), 64'(prev_cout));
            if (midstart && i == 1) begin
                start = 1'b1;
                a = W'(16'hAAAA);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("sum", 64'(sum), 64'(full[W-1:0]));
        chk("cout", 64'(cout), 64'(full[W]));
        chk("overflow", 64'(overflow), 64'(eovf));
        prev_sum  = full[W-1:0];
        prev_cout = full[W];
        prev_ovf  = eovf;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef ADDER_SUB_EN
        sub = 1'b0;
`endif
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;

        // Reset held two cycles, then three quiet cycles.
        tick();
        chk_quiet("reset1");
        tick();
        chk_quiet("reset2");
        reset = 1'b0;
        idle(3);

        // Basic addition.
        op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        idle(1);
        // Full carry ripple, then signed overflow.
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        idle(1);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Carry-in only.
        op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        idle(1);

        // A mid-RUN start is ignored, and a start held in DONE goes back-to-back.
        op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
        op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Reset during the second RUN cycle discards the operation.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_busy1", 64'(busy), 64'd1);
        tick();
        chk("abort_busy2", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        chk_quiet("abort");
        idle(NIB + 1);

        // Reset and start on the same edge: reset wins.
        a = 16'h0101; b = 16'h0101; start = 1'b1; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        chk_quiet("rst_vs_start");
        idle(1);

`ifdef ADDER_SUB_EN
        op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        idle(1);
        op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
        idle(1);
`endif

        // Randomized operations with random back-to-back chaining.
        for (int k = 0; k < 40; k++) begin
            logic tsub;
            tsub = 1'b0;
`ifdef ADDER_SUB_EN
            tsub = 1'($urandom);
`endif
            op(W'($urandom), W'($urandom), 1'($urandom), tsub, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                idle(int'($urandom_range(1, 3)));
            end
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
